// File: rtl/data_cache_wb.sv
// data_cache_wb: direct-mapped, write-back, write-allocate data cache in front of main_memory.
//   clk_i            rising-edge clock
//   rst_n_i          synchronous active-low reset
//   addr_i           byte address (block = [13:5], word = [4:2])
//   memread_i        load request, held while clk_stall_o is high
//   memwrite_i       store request, held while clk_stall_o is high
//   write_data_i     store data
//   byte_en_i        store byte strobes
//   read_data_o      load data, valid when memread_i and clk_stall_o low
//   clk_stall_o      request cannot complete this cycle
//   mem_block_addr_o line address to main_memory
//   mem_readmem_o    line fill request
//   mem_writemem_o   dirty line write-back strobe
//   mem_data_write_o victim line data
//   mem_data_read_i  fill line data
module data_cache_wb #(
    parameter int NUM_LINES   = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [31:0]  addr_i,
    input  logic         memread_i,
    input  logic         memwrite_i,
    input  logic [31:0]  write_data_i,
    input  logic [3:0]   byte_en_i,
    output logic [31:0]  read_data_o,
    output logic         clk_stall_o,
    output logic [8:0]   mem_block_addr_o,
    output logic         mem_readmem_o,
    output logic         mem_writemem_o,
    output logic [255:0] mem_data_write_o,
    input  logic [255:0] mem_data_read_i
);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = 9 - INDEX_W;
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {IDLE, EVICT, FILL_REQ, FILL_WAIT} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [255:0]         data_q [NUM_LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         word;
    logic               req, hit, install, wr_hit;
    logic [255:0]       line, merged;
    logic               unused_addr;

    assign idx         = addr_i[5+INDEX_W-1:5];
    assign tag         = addr_i[13:5+INDEX_W];
    assign word        = addr_i[4:2];
    assign unused_addr = ^{addr_i[31:14], addr_i[1:0]};
    assign req         = memread_i || memwrite_i;
    assign line        = data_q[idx];
    assign hit         = valid_q[idx] && (tag_q[idx] == tag);
    assign wr_hit      = (state_q == IDLE) && memwrite_i && hit;

    always_comb begin
        merged = line;
        for (int b = 0; b < 4; b++)
            if (byte_en_i[b]) merged[32*word+8*b +: 8] = write_data_i[8*b +: 8];
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        install          = 1'b0;
        clk_stall_o      = 1'b0;
        read_data_o      = '0;
        mem_readmem_o    = 1'b0;
        mem_writemem_o   = 1'b0;
        mem_block_addr_o = '0;
        mem_data_write_o = '0;
        case (state_q)
            IDLE: begin
                clk_stall_o = req && !hit;
                // a simultaneous write still returns the pre-merge word
                read_data_o = (memread_i && hit) ? line[32*word +: 32] : '0;
                if (req && !hit) state_d = (valid_q[idx] && dirty_q[idx]) ? EVICT : FILL_REQ;
            end
            EVICT: begin
                clk_stall_o      = 1'b1;
                mem_writemem_o   = 1'b1;
                mem_block_addr_o = {tag_q[idx], idx};
                mem_data_write_o = line;
                state_d          = FILL_REQ;
            end
            FILL_REQ: begin
                clk_stall_o      = 1'b1;
                mem_readmem_o    = 1'b1;
                mem_block_addr_o = addr_i[13:5];
                cnt_d            = CNT_W'(MEM_LATENCY - 1);
                install          = (MEM_LATENCY == 1);
                state_d          = install ? IDLE : FILL_WAIT;
            end
            FILL_WAIT: begin
                clk_stall_o      = 1'b1;
                mem_readmem_o    = 1'b1;
                mem_block_addr_o = addr_i[13:5];
                cnt_d            = cnt_q - 1'b1;
                // the fill data is valid once the count is about to reach zero
                install          = (cnt_q == CNT_W'(1));
                state_d          = install ? IDLE : FILL_WAIT;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n_i) begin
            clk_stall_o      = 1'b0;
            read_data_o      = '0;
            mem_readmem_o    = 1'b0;
            mem_writemem_o   = 1'b0;
            mem_block_addr_o = '0;
            mem_data_write_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == EVICT) dirty_q[idx] <= 1'b0;
            if (install) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (wr_hit) dirty_q[idx] <= 1'b1;
        end
    end

    // line storage needs no reset: valid_q gates every use
    always_ff @(posedge clk_i) begin
        if (install) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_data_read_i;
        end
        if (wr_hit) data_q[idx] <= merged;
    end
endmodule

// File: tb/tb_data_cache_wb.sv
module tb_data_cache_wb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, memread, memwrite, init;
    logic [31:0] addr, write_data;
    logic [3:0]  byte_en;

    logic [31:0]  rdo [2];
    logic         stall [2], mrd [2], mwr [2];
    logic [8:0]   mba [2];
    logic [255:0] mdw [2], mdr [2];
    int           lat [2] = '{1, 4};

    data_cache_wb #(.NUM_LINES(16), .MEM_LATENCY(1)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr), .memread_i(memread), .memwrite_i(memwrite),
        .write_data_i(write_data), .byte_en_i(byte_en), .read_data_o(rdo[0]), .clk_stall_o(stall[0]),
        .mem_block_addr_o(mba[0]), .mem_readmem_o(mrd[0]), .mem_writemem_o(mwr[0]),
        .mem_data_write_o(mdw[0]), .mem_data_read_i(mdr[0]));

    data_cache_wb #(.NUM_LINES(16), .MEM_LATENCY(4)) u4 (
        .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr), .memread_i(memread), .memwrite_i(memwrite),
        .write_data_i(write_data), .byte_en_i(byte_en), .read_data_o(rdo[1]), .clk_stall_o(stall[1]),
        .mem_block_addr_o(mba[1]), .mem_readmem_o(mrd[1]), .mem_writemem_o(mwr[1]),
        .mem_data_write_o(mdw[1]), .mem_data_read_i(mdr[1]));

    // main memory per DUT: fill data only valid MEM_LATENCY-1 cycles after readmem rises
    logic [255:0] mem [2][512];
    logic [255:0] refmem [512];
    int           rcnt [2];

    always @(posedge clk)
        for (int k = 0; k < 2; k++) begin
            if (init) for (int i = 0; i < 512; i++) mem[k][i] <= refmem[i];
            else if (mwr[k]) mem[k][mba[k]] <= mdw[k];
            rcnt[k] <= mrd[k] ? rcnt[k] + 1 : 0;
        end

    always_comb
        for (int k = 0; k < 2; k++)
            mdr[k] = (mrd[k] && rcnt[k] >= lat[k] - 1) ? mem[k][mba[k]] : {8{32'hBAD0BAD0}};

    int checks = 0, fails = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // reference cache: plain arrays, index = block % 16, tag = block / 16
    bit           rv [16], rdy [16];
    int           rtg [16];
    logic [255:0] rdat [16];

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) begin
            rv[i]  = 0;
            rdy[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 0; memread = 0; memwrite = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ctl", {stall[k], mrd[k], mwr[k], rdo[k], mba[k]}, '0);
            chk("rst_mdw", mdw[k], '0);
        end
        @(posedge clk);
        #1 rst_n = 1;
        ref_reset();
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        int blk, idx, tg, wd, hit, ev, ev_a;
        logic [255:0] evd;
        logic [31:0]  exp_rd;
        int           nst [2], nrm [2], nwm [2];
        logic [8:0]   wa [2];
        logic [255:0] wdat [2];
        logic [31:0]  got [2];
        bit           done [2];
        blk  = int'(a[13:5]);
        idx  = blk % 16;
        tg   = blk / 16;
        wd   = int'(a[4:2]);
        hit  = (rv[idx] && rtg[idx] == tg) ? 1 : 0;
        ev   = (!hit && rv[idx] && rdy[idx]) ? 1 : 0;
        ev_a = rtg[idx] * 16 + idx;
        evd  = rdat[idx];
        if (ev != 0) refmem[ev_a] = evd;
        if (hit == 0) begin
            rv[idx]   = 1;
            rdy[idx]  = 0;
            rtg[idx]  = tg;
            rdat[idx] = refmem[blk];
        end
        exp_rd = rdat[idx][32*wd +: 32];
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) rdat[idx][32*wd+8*b +: 8] = d[8*b +: 8];
            rdy[idx] = 1;
        end
        for (int k = 0; k < 2; k++) begin
            nst[k] = 0; nrm[k] = 0; nwm[k] = 0; done[k] = 0;
            wa[k] = 'x; wdat[k] = 'x; got[k] = 'x;
        end
        @(posedge clk);
        #1 addr = a; write_data = d; byte_en = be; memread = r; memwrite = w;
        for (int c = 0; c < 20 && !(done[0] && done[1]); c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                if (!done[k]) begin
                    if (stall[k]) begin
                        nst[k]++;
                        if (mrd[k]) begin
                            nrm[k]++;
                            chk("fill_addr", mba[k], a[13:5]);
                        end
                        if (mwr[k]) begin
                            nwm[k]++;
                            wa[k]   = mba[k];
                            wdat[k] = mdw[k];
                        end
                    end else begin
                        done[k] = 1;
                        got[k]  = rdo[k];
                        chk("done_strobes", {mrd[k], mwr[k]}, 2'b00);
                    end
                end
        end
        for (int k = 0; k < 2; k++) begin
            chk("completed", done[k], 1'b1);
            chk("stall_len", nst[k], (hit != 0) ? 0 : lat[k] + 1 + ev);
            chk("readmem_len", nrm[k], (hit != 0) ? 0 : lat[k]);
            chk("writemem_cnt", nwm[k], ev);
            if (ev != 0) begin
                chk("evict_addr", wa[k], ev_a);
                chk("evict_data", wdat[k], evd);
            end
            if (r) chk("read_data", got[k], exp_rd);
        end
        @(posedge clk);
        #1 memread = 0; memwrite = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk("idle_out", {stall[k], mrd[k], mwr[k], rdo[k]}, '0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          op;
        rst_n = 0; memread = 0; memwrite = 0; addr = 0; write_data = 0; byte_en = 0; init = 1;
        for (int i = 0; i < 512; i++)
            refmem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1 init = 0;
        do_reset();

        access(1, 0, 32'h40, 0, 0);
        access(1, 0, 32'h44, 0, 0);
        access(0, 1, 32'h48, 32'hDEADBEEF, 4'b0011);
        access(1, 0, 32'h48, 0, 0);
        access(1, 0, 32'h240, 0, 0);
        for (int k = 0; k < 2; k++) chk("wb_block2", mem[k][2], refmem[2]);
        access(0, 1, 32'h80, $urandom, 4'($urandom));
        access(1, 0, 32'h280, 0, 0);
        for (int k = 0; k < 2; k++) chk("wb_block4", mem[k][4], refmem[4]);
        access(1, 1, 32'h284, $urandom, 4'b1100);
        access(0, 1, 32'h288, $urandom, 4'b0000);
        access(1, 0, 32'h88, 0, 0);

        for (int n = 0; n < 80; n++) begin
            a = $urandom;
            a[13:5] = 9'($urandom_range(0, 3) * 16 + $urandom_range(0, 3));
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, a, $urandom, 4'($urandom));
        end

        do_reset();
        access(0, 1, 32'h60, $urandom, 4'hF);
        access(1, 0, 32'h60, 0, 0);
        @(posedge clk);
        #1 addr = 32'h80; memread = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("fillwait_stall", stall[1], 1'b1);
        chk("fillwait_rm", mrd[1], 1'b1);
        rst_n = 0; memread = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("midrst_ctl", {stall[k], mrd[k], mwr[k], rdo[k], mba[k]}, '0);
            chk("midrst_mdw", mdw[k], '0);
        end
        @(posedge clk);
        #1 rst_n = 1;
        ref_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("post_rst", {stall[k], mrd[k], mwr[k]}, '0);
        access(1, 0, 32'h60, 0, 0);
        access(1, 0, 32'h80, 0, 0);

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++) chk("final_mem", mem[k][i], refmem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
